aggregating_pipeline_feeder: RTL and testbench

// - Drives the input side and reads the result side of one aggregatingPermutePipeline.
// - Input side: accepts bot 6-packs from an upstream valid/ready stream and issues writeData/batchDone.
//   It throttles on slowDownInput.
// - Output side: pops results with grabResults and tags each with its batch id.
//   It presents them on a valid/ready stream to the result collector.

---
 rtl/aggregating_pipeline_feeder.sv | 156 +++++++++++++++
 tb/tb_aggregating_pipeline_feeder.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aggregating_pipeline_feeder.sv
// aggregating_pipeline_feeder: streams bot 6-packs into an aggregatingPermutePipeline and
// returns its per-batch results tagged with batch ids. Define FEEDER_STATS_EN for statistics counters.
module aggregating_pipeline_feeder #(
    parameter int PCOUNT_W        = 35,
    parameter int RESULT_LATENCY  = 2,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [127:0]                    inBot,
    input  logic [5:0]                      inValidPermutes,
    input  logic                            inLast,
    input  logic                            inValid,
    output logic                            inReady,
    output logic [127:0]                    bot,
    output logic [5:0]                      validBotPermutes,
    output logic                            batchDone,
    output logic                            writeData,
    input  logic                            slowDownInput,
    input  logic                            resultsAvailable,
    output logic                            grabResults,
    input  logic [PCOUNT_W+34:0]            pcoeffSum,
    input  logic [PCOUNT_W-1:0]             pcoeffCount,
    output logic                            resValid,
    input  logic                            resReady,
    output logic [PCOUNT_W+34:0]            resSum,
    output logic [PCOUNT_W-1:0]             resCount,
    output logic [15:0]                     resBatchId,
`ifdef FEEDER_STATS_EN
    output logic [31:0]                     statBotsWritten,
    output logic [31:0]                     statStallCycles,
    output logic [31:0]                     statBatchesDone,
`endif
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int LAT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESULT_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD} rstate_t;

    rstate_t          r_state;
    logic [LAT_W-1:0] r_latCnt;
    logic [15:0]      r_wrBatchId;
    logic [15:0]      r_rdBatchId;
    logic             w_accept;
    logic             w_close;
    logic             w_grabStart;

    assign inReady     = !slowDownInput && (outstanding < MAX_OUT);
    assign w_accept    = inValid && inReady;
    assign w_close     = w_accept && inLast;
    assign w_grabStart = (r_state == R_IDLE) && resultsAvailable && (outstanding != '0) && !resValid;

    // Bots with no valid permutes are swallowed unless they close the batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bot              <= '0;
            validBotPermutes <= '0;
            writeData        <= 1'b0;
            batchDone        <= 1'b0;
        end else begin
            writeData <= w_accept && ((|inValidPermutes) || inLast);
            batchDone <= w_close;
            if (w_accept) begin
                bot              <= inBot;
                validBotPermutes <= inValidPermutes;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            r_wrBatchId <= '0;
        end else begin
            if (w_close) begin
                r_wrBatchId <= r_wrBatchId + 16'd1;
            end
            case ({w_close, w_grabStart})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The grab cycle itself is not counted; the countdown covers the FIFO read latency after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= R_IDLE;
            r_latCnt    <= '0;
            r_rdBatchId <= '0;
            grabResults <= 1'b0;
            resValid    <= 1'b0;
            resSum      <= '0;
            resCount    <= '0;
            resBatchId  <= '0;
        end else begin
            grabResults <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (w_grabStart) begin
                        grabResults <= 1'b1;
                        r_latCnt    <= LAT_LOAD;
                        r_state     <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (!grabResults) begin
                        if (r_latCnt != '0) begin
                            r_latCnt <= r_latCnt - LAT_W'(1);
                        end else begin
                            resSum      <= pcoeffSum;
                            resCount    <= pcoeffCount;
                            resBatchId  <= r_rdBatchId;
                            r_rdBatchId <= r_rdBatchId + 16'd1;
                            resValid    <= 1'b1;
                            r_state     <= R_HOLD;
                        end
                    end
                end
                R_HOLD: begin
                    if (resReady) begin
                        resValid <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef FEEDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statBotsWritten <= '0;
            statStallCycles <= '0;
            statBatchesDone <= '0;
        end else begin
            if (writeData && (statBotsWritten != 32'hFFFF_FFFF)) begin
                statBotsWritten <= statBotsWritten + 32'd1;
            end
            if (inValid && !inReady && (statStallCycles != 32'hFFFF_FFFF)) begin
                statStallCycles <= statStallCycles + 32'd1;
            end
            if (resValid && resReady && (statBatchesDone != 32'hFFFF_FFFF)) begin
                statBatchesDone <= statBatchesDone + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aggregating_pipeline_feeder.sv
// tb_aggregating_pipeline_feeder: randomized self-checking bench with a cycle-level reference model
// of the feeder and a behavioural model of the pipeline's results FIFO.
module tb_aggregating_pipeline_feeder;

    localparam int PW   = 35;
    localparam int SW   = PW + 35;
    localparam int LAT  = 2;
    localparam int MAXO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   inBot;
    logic [5:0]     inValidPermutes;
    logic           inLast;
    logic           inValid;
    logic           inReady;
    logic [127:0]   bot;
    logic [5:0]     validBotPermutes;
    logic           batchDone;
    logic           writeData;
    logic           slowDownInput;
    logic           resultsAvailable;
    logic           grabResults;
    logic [SW-1:0]  pcoeffSum;
    logic [PW-1:0]  pcoeffCount;
    logic           resValid;
    logic           resReady;
    logic [SW-1:0]  resSum;
    logic [PW-1:0]  resCount;
    logic [15:0]    resBatchId;
    logic [6:0]     outstanding;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aggregating_pipeline_feeder #(
        .PCOUNT_W(PW), .RESULT_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .inBot(inBot), .inValidPermutes(inValidPermutes),
        .inLast(inLast), .inValid(inValid), .inReady(inReady), .bot(bot),
        .validBotPermutes(validBotPermutes), .batchDone(batchDone), .writeData(writeData),
        .slowDownInput(slowDownInput), .resultsAvailable(resultsAvailable),
        .grabResults(grabResults), .pcoeffSum(pcoeffSum), .pcoeffCount(pcoeffCount),
        .resValid(resValid), .resReady(resReady), .resSum(resSum), .resCount(resCount),
        .resBatchId(resBatchId), .outstanding(outstanding)
    );

    // Pipeline results FIFO: data is valid only LAT cycles after a grab, garbage otherwise.
    logic [1:0]    gHist;
    logic [SW-1:0] pSum;
    logic [PW-1:0] pCount;
    logic [SW-1:0] nextSum;
    logic [PW-1:0] nextCount;
    bit            randData;

    always @(negedge clk) begin
        if (rst) begin
            gHist       = 2'b00;
            pcoeffSum   = SW'({$urandom(), $urandom(), $urandom()});
            pcoeffCount = PW'({$urandom(), $urandom()});
        end else begin
            if (gHist[1]) begin
                pSum        = randData ? SW'({$urandom(), $urandom(), $urandom()}) : nextSum;
                pCount      = randData ? PW'({$urandom(), $urandom()}) : nextCount;
                pcoeffSum   = pSum;
                pcoeffCount = pCount;
            end else begin
                pcoeffSum   = SW'({$urandom(), $urandom(), $urandom()});
                pcoeffCount = PW'({$urandom(), $urandom()});
            end
            gHist = {gHist[0], grabResults};
        end
    end

    // Reference model: batch accounting plus a result timeline of grab, LAT+1 cycles, then hold.
    int            mOut, mRd, mWait, mId;
    bit            mBusy, mValid, mGrab, mWrite, mDone, mAcc, mGrabNow;
    logic [127:0]  mBot;
    logic [5:0]    mPerm;
    logic [SW-1:0] mSum;
    logic [PW-1:0] mCount;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mOut = 0; mRd = 0; mWait = 0; mId = 0;
            mBusy = 0; mValid = 0; mGrab = 0; mWrite = 0; mDone = 0;
            mBot = '0; mPerm = '0; mSum = '0; mCount = '0;
        end else begin
            mAcc   = inValid && !slowDownInput && (mOut < MAXO);
            mWrite = mAcc && ((inValidPermutes != 6'd0) || inLast);
            mDone  = mAcc && inLast;
            if (mAcc) begin
                mBot  = inBot;
                mPerm = inValidPermutes;
            end
            mGrabNow = 0;
            if (!mBusy) begin
                if (resultsAvailable && mOut != 0) begin
                    mGrabNow = 1;
                    mBusy    = 1;
                    mWait    = LAT + 1;
                end
            end else if (mWait > 0) begin
                mWait--;
                if (mWait == 0) begin
                    mValid = 1;
                    mId    = mRd % 65536;
                    mRd++;
                    mSum   = pSum;
                    mCount = pCount;
                end
            end else if (resReady) begin
                mValid = 0;
                mBusy  = 0;
            end
            mGrab = mGrabNow;
            mOut  = mOut + (mDone ? 1 : 0) - (mGrabNow ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        inValid = 0; inLast = 0; inValidPermutes = '0;
        slowDownInput = 0; resultsAvailable = 0; resReady = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        quiet();
        inBot = '0;
        randData = 0; nextSum = '0; nextCount = '0;
        repeat (2) tick();
        checks++;
        if ({writeData, batchDone, bot, validBotPermutes, grabResults, resValid, resSum, resCount, resBatchId} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got wd=%0b bd=%0b bot=%0h grab=%0b rv=%0b sum=%0h id=%0h expected all 0",
                     writeData, batchDone, bot, grabResults, resValid, resSum, resBatchId);
        end
        checks++;
        if (outstanding !== 7'd0) begin
            failures++;
            $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding);
        end
        checks++;
        if (inReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_inReady: got %0b expected 1", inReady);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_basic_batch();
        logic [5:0] perms [3];
        int writes;
        perms[0] = 6'h3F; perms[1] = 6'h00; perms[2] = 6'h01;
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            inValid = 1; inLast = (i == 2); inValidPermutes = perms[i];
            inBot = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            writes += int'(writeData);
            checks++;
            if (writeData !== mWrite || batchDone !== mDone || bot !== mBot || validBotPermutes !== mPerm) begin
                failures++;
                $display("[TB] FAIL basic_bot%0d: got wd=%0b bd=%0b perm=%0h bot=%0h expected wd=%0b bd=%0b perm=%0h bot=%0h",
                         i, writeData, batchDone, validBotPermutes, bot, mWrite, mDone, mPerm, mBot);
            end
        end
        quiet();
        checks++;
        if (writes !== 2 || batchDone !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_writes: got %0d writes last bd=%0b expected 2 writes last bd=1", writes, batchDone);
        end
        checks++;
        if (outstanding !== 7'd1) begin
            failures++;
            $display("[TB] FAIL basic_outstanding: got %0d expected 1", outstanding);
        end
    endtask

    task automatic test_slowdown();
        for (int i = 0; i < 10; i++) begin
            slowDownInput = 1; inValid = 1; inLast = 1; inValidPermutes = 6'h15;
            inBot = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            checks++;
            if (inReady !== 1'b0) begin
                failures++;
                $display("[TB] FAIL slow_inReady%0d: got %0b expected 0", i, inReady);
            end
            tick();
            checks++;
            if (writeData !== 1'b0 || outstanding !== 7'd1) begin
                failures++;
                $display("[TB] FAIL slow_write%0d: got wd=%0b out=%0d expected wd=0 out=1", i, writeData, outstanding);
            end
        end
        quiet();
    endtask

    task automatic test_fill_outstanding();
        for (int i = 0; i < 80 && mOut < MAXO; i++) begin
            inValid = 1; inLast = 1; inValidPermutes = 6'($urandom());
            inBot = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        quiet();
        #1;
        checks++;
        if (outstanding !== 7'd64 || inReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_full: got out=%0d rdy=%0b expected out=64 rdy=0", outstanding, inReady);
        end
        inValid = 1; inLast = 1; inValidPermutes = 6'h07;
        repeat (2) tick();
        quiet();
        checks++;
        if (writeData !== 1'b0 || outstanding !== 7'd64) begin
            failures++;
            $display("[TB] FAIL fill_blocked: got wd=%0b out=%0d expected wd=0 out=64", writeData, outstanding);
        end
    endtask

    task automatic test_result_timing();
        bit found;
        found = 0;
        randData = 0; nextSum = SW'(100); nextCount = PW'(7);
        resultsAvailable = 1; resReady = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grabResults === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || outstanding !== 7'd63 || inReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL grab_start: got grab=%0b out=%0d rdy=%0b expected grab=1 out=63 rdy=1",
                     found, outstanding, inReady);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (resValid !== (k == 3)) begin
                failures++;
                $display("[TB] FAIL result_latency_T+%0d: got resValid=%0b expected %0b", k, resValid, (k == 3));
            end
        end
        checks++;
        if (resSum !== SW'(100) || resCount !== PW'(7) || resBatchId !== 16'd0) begin
            failures++;
            $display("[TB] FAIL result_value: got sum=%0d cnt=%0d id=%0d expected sum=100 cnt=7 id=0",
                     resSum, resCount, resBatchId);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (resValid !== 1'b1 || grabResults !== 1'b0 || resSum !== SW'(100) || outstanding !== 7'd63) begin
                failures++;
                $display("[TB] FAIL result_hold%0d: got rv=%0b grab=%0b sum=%0d out=%0d expected rv=1 grab=0 sum=100 out=63",
                         k, resValid, grabResults, resSum, outstanding);
            end
        end
        resultsAvailable = 0; resReady = 1;
        tick();
        checks++;
        if (resValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL result_release: got resValid=%0b expected 0", resValid);
        end
        resReady = 0;
    endtask

    task automatic test_same_cycle();
        bit found;
        found = 0;
        nextSum = SW'({$urandom(), $urandom(), $urandom()});
        nextCount = PW'({$urandom(), $urandom()});
        resultsAvailable = 1; inValid = 1; inLast = 1; inValidPermutes = 6'h21;
        tick();
        quiet();
        checks++;
        if (grabResults !== 1'b1 || batchDone !== 1'b1 || outstanding !== 7'd63) begin
            failures++;
            $display("[TB] FAIL same_cycle: got grab=%0b bd=%0b out=%0d expected grab=1 bd=1 out=63",
                     grabResults, batchDone, outstanding);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resValid === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || resSum !== nextSum || resCount !== nextCount || resBatchId !== 16'd1) begin
            failures++;
            $display("[TB] FAIL same_cycle_result: got rv=%0b sum=%0h cnt=%0h id=%0d expected rv=1 sum=%0h cnt=%0h id=1",
                     found, resSum, resCount, resBatchId, nextSum, nextCount);
        end
        resReady = 1;
        tick();
        resReady = 0;
    endtask

    task automatic test_empty_batch();
        inValid = 1; inLast = 1; inValidPermutes = 6'h00;
        inBot = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        quiet();
        checks++;
        if (writeData !== 1'b1 || batchDone !== 1'b1 || validBotPermutes !== 6'h00 || outstanding !== 7'd64) begin
            failures++;
            $display("[TB] FAIL empty_batch: got wd=%0b bd=%0b perm=%0h out=%0d expected wd=1 bd=1 perm=0 out=64",
                     writeData, batchDone, validBotPermutes, outstanding);
        end
    endtask

    task automatic test_random();
        randData = 1;
        for (int i = 0; i < 400; i++) begin
            inValid          = ($urandom_range(0, 9) < 7);
            inLast           = ($urandom_range(0, 4) == 0);
            inValidPermutes  = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom());
            inBot            = {$urandom(), $urandom(), $urandom(), $urandom()};
            slowDownInput    = ($urandom_range(0, 4) == 0);
            resultsAvailable = ($urandom_range(0, 1) == 1);
            resReady         = ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (inReady !== (!slowDownInput && mOut < MAXO)) begin
                failures++;
                $display("[TB] FAIL rand_inReady%0d: got %0b expected %0b", i, inReady, (!slowDownInput && mOut < MAXO));
            end
            tick();
            checks++;
            if (writeData !== mWrite || batchDone !== mDone || bot !== mBot || validBotPermutes !== mPerm) begin
                failures++;
                $display("[TB] FAIL rand_input%0d: got wd=%0b bd=%0b perm=%0h expected wd=%0b bd=%0b perm=%0h",
                         i, writeData, batchDone, validBotPermutes, mWrite, mDone, mPerm);
            end
            checks++;
            if (outstanding !== 7'(mOut) || grabResults !== mGrab || resValid !== mValid) begin
                failures++;
                $display("[TB] FAIL rand_result_ctl%0d: got out=%0d grab=%0b rv=%0b expected out=%0d grab=%0b rv=%0b",
                         i, outstanding, grabResults, resValid, mOut, mGrab, mValid);
            end
            if (mValid) begin
                checks++;
                if (resSum !== mSum || resCount !== mCount || resBatchId !== 16'(mId)) begin
                    failures++;
                    $display("[TB] FAIL rand_result%0d: got sum=%0h cnt=%0h id=%0d expected sum=%0h cnt=%0h id=%0d",
                             i, resSum, resCount, resBatchId, mSum, mCount, mId);
                end
            end
        end
        quiet();
        randData = 0;
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        resReady = 1;
        repeat (6) tick();
        resReady = 0;
        if (mOut == 0) begin
            inValid = 1; inLast = 1; inValidPermutes = 6'h01;
            tick();
            quiet();
        end
        inValid = 1; inLast = 0; inValidPermutes = 6'h2A;
        inBot = {$urandom(), $urandom(), $urandom(), $urandom()};
        resultsAvailable = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            inValid = 0;
            if (grabResults === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL midreset_grab: got no grab within 8 cycles expected a grab");
        end
        resultsAvailable = 0;
        tick();
        #2 rst = 1;
        #1;
        checks++;
        if ({writeData, batchDone, bot, validBotPermutes, grabResults, resValid, resSum, resCount, resBatchId, outstanding} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_async: got wd=%0b bot=%0h rv=%0b sum=%0h id=%0d out=%0d expected all 0",
                     writeData, bot, resValid, resSum, resBatchId, outstanding);
        end
        repeat (2) tick();
        rst = 0;
        nextSum = SW'({$urandom(), $urandom(), $urandom()});
        nextCount = PW'({$urandom(), $urandom()});
        inValid = 1; inLast = 1; inValidPermutes = 6'h05;
        tick();
        quiet();
        resultsAvailable = 1;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (resValid === 1'b1) begin
                found = 1;
                break;
            end
        end
        resultsAvailable = 0;
        checks++;
        if (!found || resBatchId !== 16'd0 || resSum !== nextSum || resCount !== nextCount) begin
            failures++;
            $display("[TB] FAIL midreset_next_id: got rv=%0b id=%0d sum=%0h expected rv=1 id=0 sum=%0h",
                     found, resBatchId, resSum, nextSum);
        end
        resReady = 1;
        tick();
        resReady = 0;
    endtask

    initial begin
        test_reset();
        test_basic_batch();
        test_slowdown();
        test_fill_outstanding();
        test_result_timing();
        test_same_cycle();
        test_empty_batch();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
